// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: hardware-triggered end-of-run monitor for the MIPS core.
// While armed it counts cycles and watches the PC. On a halt (PC parked at
// halt_pc) or a timeout it stalls the core. It then streams a PC record, a
// cycle-count record and every register-file entry over a valid/ready port.
module regfile_dump_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int NREGS     = 32,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 16,
  parameter int HALT_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   halt_pc,
  input  logic [CNT_W-1:0]  timeout,
  output logic              cpu_stall,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              timed_out
);

  localparam int REC_W  = $clog2(NREGS + 2);
  localparam int HOLD_W = $clog2(HALT_HOLD + 1);
  localparam logic [REC_W-1:0] LAST_REC = REC_W'(NREGS + 1);

  typedef enum logic [2:0] {IDLE, RUN, LOAD, SEND, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cyc_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic [PC_W-1:0]     pcSnap_q;
  logic [REC_W-1:0]    rec_q;
  logic                stall_q;
  logic                valid_q;
  logic                done_q;
  logic                timedOut_q;
  logic [1:0]          kind_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic                haltHit;
  logic                timeHit;
  logic [IDX_W-1:0]    regIdx;

  // Trigger decode: next consecutive-match count, halt/timeout hits, register index of the current record
  always_comb begin
    hold_d  = (pc == halt_pc) ? hold_q + HOLD_W'(1) : '0;
    haltHit = (hold_d == HOLD_W'(HALT_HOLD));
    timeHit = (timeout != '0) &&
              (({1'b0, cyc_q} + (CNT_W + 1)'(1)) == {1'b0, timeout});
    regIdx  = IDX_W'(rec_q - REC_W'(2));
  end

  // The spare read port only points at a register while a register record is being loaded
  assign rf_raddr  = (state_q == LOAD && rec_q >= REC_W'(2)) ? regIdx : '0;
  assign cpu_stall = stall_q;
  assign out_valid = valid_q;
  assign out_kind  = kind_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign done      = done_q;
  assign timed_out = timedOut_q;

  // Main sequencer: arm, count, trigger, then present one record per LOAD/SEND pair; halt beats timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      hold_q     <= '0;
      pcSnap_q   <= '0;
      rec_q      <= '0;
      stall_q    <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      timedOut_q <= 1'b0;
      kind_q     <= 2'd0;
      idx_q      <= '0;
      data_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cyc_q  <= '0;
          hold_q <= '0;
          if (en) state_q <= RUN;
        end
        RUN: begin
          if (!en) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            hold_q  <= '0;
          end else if (haltHit || timeHit) begin
            pcSnap_q   <= pc;
            rec_q      <= '0;
            stall_q    <= 1'b1;
            timedOut_q <= !haltHit;
            state_q    <= LOAD;
          end else begin
            hold_q <= hold_d;
            if (!(&cyc_q)) cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        LOAD: begin
          valid_q <= 1'b1;
          if (rec_q == '0) begin
            kind_q <= 2'd0;
            idx_q  <= '0;
            data_q <= DATA_W'(pcSnap_q);
          end else if (rec_q == REC_W'(1)) begin
            kind_q <= 2'd1;
            idx_q  <= '0;
            data_q <= DATA_W'(cyc_q);
          end else begin
            kind_q <= 2'd2;
            idx_q  <= regIdx;
            data_q <= rf_rdata;
          end
          state_q <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (rec_q == LAST_REC) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rec_q   <= rec_q + REC_W'(1);
              state_q <= LOAD;
            end
          end
        end
        DONE: begin
          if (!en) begin
            done_q     <= 1'b0;
            timedOut_q <= 1'b0;
            stall_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: directed scenarios with random register contents and
// random sink backpressure, checked against a record-list model of the dump.
module tb_regfile_dump_unit;

  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;
  localparam int NREGS     = 32;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 16;
  localparam int HALT_HOLD = 2;
  localparam int NRECS     = NREGS + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   halt_pc;
  logic [CNT_W-1:0]  timeout;
  logic              cpu_stall;
  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_kind;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              done;
  logic              timed_out;

  typedef struct packed {
    logic [1:0]        kind;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic [DATA_W-1:0] rfModel [NREGS];
  rec_t              expQ [$];
  int                nAsserts = 0;
  int                nFails   = 0;

  int                expCyc;
  logic [PC_W-1:0]   expPc;
  logic              expTo;

  always #5 clk = ~clk;

  assign rf_rdata = rfModel[rf_raddr];

  regfile_dump_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS), .IDX_W(IDX_W),
    .CNT_W(CNT_W), .HALT_HOLD(HALT_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .halt_pc(halt_pc),
    .timeout(timeout), .cpu_stall(cpu_stall), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_idx(out_idx), .out_data(out_data),
    .done(done), .timed_out(timed_out)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFails++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {cpu_stall, out_valid, done, timed_out}, 64'd0);
    checkOutput({tag, "_rec"}, {out_kind, out_idx, out_data}, 64'd0);
    checkOutput({tag, "_raddr"}, rf_raddr, 64'd0);
  endtask

  function automatic logic [PC_W-1:0] pcFor(input int k, input int g, input int p);
    if ((g > 0 && k == g) || (p > 0 && k >= p)) return PC_W'(32'h40);
    return PC_W'(32'h1000 + 4 * k);
  endfunction

  task automatic randomizeRf();
    for (int i = 0; i < NREGS; i++) rfModel[i] = $urandom();
  endtask

  // Arms the unit and drives one pc value per RUN cycle; run cycle k ends at the k-th edge after arming.
  task automatic applyStimulus(input int glitchAt, input int parkAt, input int tmo, input int runLen);
    int tHalt;
    int tTrig;
    tHalt = (parkAt > 0) ? parkAt + HALT_HOLD - 1 : 0;
    if (tHalt == 0)      tTrig = tmo;
    else if (tmo == 0)   tTrig = tHalt;
    else                 tTrig = (tHalt < tmo) ? tHalt : tmo;
    expTo  = (tmo > 0) && (tHalt == 0 || tmo < tHalt);
    expCyc = tTrig - 1;
    expPc  = pcFor(tTrig, glitchAt, parkAt);
    @(negedge clk);
    halt_pc = PC_W'(32'h40);
    timeout = CNT_W'(tmo);
    pc      = PC_W'(32'h1000);
    en      = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= ((tTrig > 0) ? tTrig : runLen); k++) begin
      pc = pcFor(k, glitchAt, parkAt);
      @(negedge clk);
      if (tTrig > 0 && k == tTrig - 1) checkOutput("stallBeforeTrigger", cpu_stall, 64'd0);
      if (tTrig > 0 && k == tTrig)     checkOutput("stallAtTrigger", cpu_stall, 64'd1);
      if (tTrig == 0 && k == runLen)   checkOutput("stallWhileRunning", cpu_stall, 64'd0);
    end
  endtask

  // Drains the record stream, checking order, content, stability under backpressure and final status.
  task automatic collectDump(input int readyPct, input int rstAtRec);
    rec_t exp_r;
    rec_t held;
    logic wasStalled = 1'b0;
    int   nRecs  = 0;
    int   cycles = 0;
    bit   finished = 1'b0;
    expQ.delete();
    expQ.push_back({2'd0, IDX_W'(0), DATA_W'(expPc)});
    expQ.push_back({2'd1, IDX_W'(0), DATA_W'(expCyc)});
    for (int i = 0; i < NREGS; i++) expQ.push_back({2'd2, IDX_W'(i), rfModel[i]});
    held = '0;
    while (!finished && cycles < 2000) begin
      if (wasStalled)
        checkOutput("heldStable", {out_valid, out_kind, out_idx, out_data}, {1'b1, held});
      if (done) begin
        finished = 1'b1;
      end else begin
        if (rstAtRec >= 0 && nRecs == rstAtRec && out_valid) begin
          rst       = 1'b1;
          en        = 1'b0;
          out_ready = 1'b0;
          @(negedge clk);
          checkResetOutputs("resetMidDump");
          rst = 1'b0;
          return;
        end
        out_ready  = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
        wasStalled = out_valid && !out_ready;
        held       = {out_kind, out_idx, out_data};
        if (out_valid && out_ready) begin
          if (nRecs < NRECS) begin
            exp_r = expQ[nRecs];
            checkOutput($sformatf("rec%0d_kind", nRecs), out_kind, exp_r.kind);
            checkOutput($sformatf("rec%0d_idx", nRecs), out_idx, exp_r.idx);
            checkOutput($sformatf("rec%0d_data", nRecs), out_data, exp_r.data);
          end
          nRecs++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    checkOutput("doneSeen", finished, 64'd1);
    checkOutput("recordCount", nRecs, NRECS);
    if (readyPct >= 100) checkOutput("dumpLatency", cycles, 2 * NRECS);
    checkOutput("timedOut", timed_out, expTo);
    checkOutput("stallInDone", cpu_stall, 64'd1);
    checkOutput("validInDone", out_valid, 64'd0);
  endtask

  task automatic releaseDump();
    en        = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("releaseDone", done, 64'd0);
    checkOutput("releaseTimedOut", timed_out, 64'd0);
    checkOutput("releaseStall", cpu_stall, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    pc        = '0;
    halt_pc   = '0;
    timeout   = '0;
    out_ready = 1'b0;
    randomizeRf();
    repeat (2) @(negedge clk);
    checkResetOutputs("resetState");
    rst = 1'b0;

    $display("[TB] halt at parked pc, sink always ready");
    applyStimulus(0, 21, 0, 0);
    collectDump(100, -1);
    releaseDump();

    $display("[TB] timeout of 100 cycles, pc never matches");
    randomizeRf();
    applyStimulus(0, 0, 100, 0);
    collectDump(100, -1);
    releaseDump();

    $display("[TB] random backpressure, 30 percent ready");
    randomizeRf();
    applyStimulus(0, 7, 0, 0);
    collectDump(30, -1);
    releaseDump();

    $display("[TB] single-cycle pc match is ignored, later park triggers");
    randomizeRf();
    applyStimulus(10, 50, 0, 0);
    collectDump(100, -1);
    releaseDump();

    $display("[TB] abort by dropping en, then re-arm with short timeout");
    applyStimulus(0, 0, 0, 15);
    en = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abortValid", out_valid, 64'd0);
    checkOutput("abortStallDone", {cpu_stall, done}, 64'd0);
    randomizeRf();
    applyStimulus(0, 0, 5, 0);
    collectDump(100, -1);
    releaseDump();

    $display("[TB] reset while record 10 is offered, then full re-run");
    randomizeRf();
    applyStimulus(0, 5, 0, 0);
    collectDump(100, 10);
    randomizeRf();
    applyStimulus(0, 8, 0, 0);
    collectDump(100, -1);
    releaseDump();

    $display("[TB] halt and timeout in the same cycle");
    randomizeRf();
    applyStimulus(0, 29, 30, 0);
    collectDump(100, -1);
    releaseDump();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
